// File: rtl/lab2_pkg.sv
// Shared types and constants for the Lab 2 dual seven-segment display.
//   mux_state_t : display multiplexer phases
//   SEG_OFF     : all segments dark (segments are active-low)
//   DIGIT_ON/OFF: active-low digit-enable levels
//   cnt_width() : dwell counter width for a pair of phase lengths
package lab2_pkg;

    typedef enum logic [1:0] {
        BLANK1,
        SHOW1,
        BLANK2,
        SHOW2
    } mux_state_t;

    localparam logic [6:0] SEG_OFF   = 7'b1111111;
    localparam logic       DIGIT_ON  = 1'b0;
    localparam logic       DIGIT_OFF = 1'b1;

    // Bits needed to count 0..max(a,b)-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex to seven-segment decoder.
//   hex_i : 4-bit hex digit
//   seg_o : active-low segments, seg_o[0]=a ... seg_o[6]=g
module seven_seg_decoder (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        unique case (hex_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/display_mux.sv
// Two-digit time-multiplexed seven-segment driver with blanking between digits.
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   en       : run enable, low forces dark and restarts the sequence
//   s1, s2   : hex digits for display 1 / display 2
//   seg      : registered active-low segments
//   display1 : registered active-low digit-1 enable
//   display2 : registered active-low digit-2 enable
module display_mux
    import lab2_pkg::*;
#(
    parameter int unsigned ON_CYCLES    = 24000,
    parameter int unsigned BLANK_CYCLES = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] s1,
    input  logic [3:0] s2,
    output logic [6:0] seg,
    output logic       display1,
    output logic       display2
);

    localparam int unsigned CntW = cnt_width(ON_CYCLES, BLANK_CYCLES);
    typedef logic [CntW-1:0] cnt_t;
    localparam cnt_t OnLast    = cnt_t'(ON_CYCLES - 1);
    localparam cnt_t BlankLast = cnt_t'(BLANK_CYCLES - 1);

    mux_state_t state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic       run_q, run_d;
    logic [3:0] digit1_q, digit1_d;
    logic [3:0] digit2_q, digit2_d;
    logic [6:0] seg_q, seg_d;
    logic       display1_q, display1_d;
    logic       display2_q, display2_d;

    logic       expire;
    logic [3:0] dec_hex;
    logic [6:0] dec_seg;

    // Next state, dwell counter and digit capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        digit1_d = digit1_q;
        digit2_d = digit2_q;
        expire   = (state_q == BLANK1 || state_q == BLANK2) ? (cnt_q == BlankLast)
                                                             : (cnt_q == OnLast);
        if (!en) begin
            state_d = BLANK1;
            cnt_d   = '0;
            run_d   = 1'b0;
        end else if (!run_q) begin
            // After reset or an enable drop the first enabled edge is count 0 of BLANK1.
            run_d   = 1'b1;
            state_d = BLANK1;
            cnt_d   = '0;
        end else if (expire) begin
            cnt_d = '0;
            unique case (state_q)
                BLANK1: state_d = SHOW1;
                SHOW1:  state_d = BLANK2;
                BLANK2: state_d = SHOW2;
                SHOW2:  state_d = BLANK1;
            endcase
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (state_d == SHOW1 && state_q != SHOW1) digit1_d = s1;
        if (state_d == SHOW2 && state_q != SHOW2) digit2_d = s2;
        dec_hex = (state_d == SHOW2) ? digit2_d : digit1_d;
    end

    seven_seg_decoder u_dec (
        .hex_i (dec_hex),
        .seg_o (dec_seg)
    );

    // Output registers track the state being entered, so pins change on the entry edge.
    always_comb begin
        seg_d      = SEG_OFF;
        display1_d = DIGIT_OFF;
        display2_d = DIGIT_OFF;
        unique case (state_d)
            SHOW1: begin
                seg_d      = dec_seg;
                display1_d = DIGIT_ON;
            end
            SHOW2: begin
                seg_d      = dec_seg;
                display2_d = DIGIT_ON;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= BLANK1;
            cnt_q      <= '0;
            run_q      <= 1'b0;
            digit1_q   <= 4'h0;
            digit2_q   <= 4'h0;
            seg_q      <= SEG_OFF;
            display1_q <= DIGIT_OFF;
            display2_q <= DIGIT_OFF;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            run_q      <= run_d;
            digit1_q   <= digit1_d;
            digit2_q   <= digit2_d;
            seg_q      <= seg_d;
            display1_q <= display1_d;
            display2_q <= display2_d;
        end
    end

    assign seg      = seg_q;
    assign display1 = display1_q;
    assign display2 = display2_q;

endmodule

// File: doc/display_mux.md
# display_mux

Two-digit time-multiplexed seven-segment driver for the Lab 2 dual-display board. It takes two 4-bit hex digits, which are the switch values, and alternately lights display 1 and display 2. Each digit phase is preceded by a blanking interval so that segment data never overlaps a digit-enable transition (no ghosting). It sits directly downstream of the switch inputs and drives the `seg`, `display1` and `display2` pins of the lab2_eo top level.

## Interface
- `ON_CYCLES`, default 24000: clk cycles each digit is lit (≈1 ms at 24 MHz); must be ≥ 1.
- `BLANK_CYCLES`, default 240: clk cycles both digits are dark before each digit phase; must be ≥ 1.
- `clk` in 1: system clock; all flops on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `en` in 1: run enable; low forces dark.
- `s1` in 4: hex digit shown on display 1.
- `s2` in 4: hex digit shown on display 2.
- `seg` out 7: segment drive, active-low, `seg[0]`=a … `seg[6]`=g.
- `display1` out 1: digit-1 enable, active-low (0 = lit).
- `display2` out 1: digit-2 enable, active-low.

## Operation
- FSM states: BLANK1 → SHOW1 → BLANK2 → SHOW2 → BLANK1.
- BLANK1 and BLANK2 each last BLANK_CYCLES. SHOW1 and SHOW2 each last ON_CYCLES.
- Dwell counter: counts 0..N-1 in each state. At N-1 it advances state and clears to 0. Width is `$clog2(max(ON_CYCLES, BLANK_CYCLES))`, minimum 1.
- Digit capture:
  - `digit1_q` loads `s1` on the edge entering SHOW1.
  - `digit2_q` loads `s2` on the edge entering SHOW2.
  - Input changes mid-phase are invisible until that digit's next phase.
- Outputs, all registered (driven from flops, no combinational path from `s1`/`s2`/state to pins):
  - BLANK1/BLANK2: `seg`=7'b1111111, `display1`=1, `display2`=1.
  - SHOW1: `seg`=decode(`digit1_q`), `display1`=0, `display2`=1.
  - SHOW2: `seg`=decode(`digit2_q`), `display1`=1, `display2`=0.
  - `display1` and `display2` are never both 0, in any cycle.
- Hex decode for 0–F uses the standard patterns. Examples: 0→7'b1000000, 1→7'b1111001, 8→7'b0000000, A→7'b0001000, F→7'b0001110.
- `en` low:
  - On the next edge, state goes to BLANK1, the counter goes to 0 and outputs go dark.
  - It holds there while `en`=0.
  - When `en` returns high, the sequence restarts from BLANK1 at count 0.
  - `en` has priority over counter expiry in the same cycle.

## Timing
- Reset (asynchronous, immediate, including mid-phase): state=BLANK1, count=0, `digit1_q`=`digit2_q`=0, `seg`=7'b1111111, `display1`=`display2`=1.
- After reset release with `en`=1, the first rising edge is count 0 of BLANK1.
- SHOW1 outputs appear on the edge BLANK_CYCLES after the first edge, with the digit captured on that same edge.
- Full frame = 2·(ON_CYCLES + BLANK_CYCLES) cycles. The per-digit duty cycle is ON_CYCLES / frame.
- State, outputs and digit capture all update on the same edge; the latency from state entry to pin is 0 cycles.
- Input-to-display latency: at most one frame.

## Structure
- Package `lab2_pkg`:
  - State enum `mux_state_t` (BLANK1, SHOW1, BLANK2, SHOW2).
  - Constant `SEG_OFF` = 7'b1111111.
  - Constants `DIGIT_ON` = 1'b0 and `DIGIT_OFF` = 1'b1.
- Sub-module `seven_seg_decoder`: combinational, 4-bit hex in, 7-bit active-low segments out. It is shared with the rest of the Lab 2 design.
- display_mux contains the FSM, the dwell counter, the digit capture registers and the output registers.

## Test plan
All scenarios use ON_CYCLES=4 and BLANK_CYCLES=2.
- Reset sequence:
  - Stimulus: hold `reset`=0 for 3 cycles, then release with `en`=1, `s1`=4'h1, `s2`=4'h8.
  - Response: dark for 2 cycles; then `seg`=7'b1111001 with `display1`=0 for 4 cycles; dark for 2 cycles; then `seg`=7'b0000000 with `display2`=0 for 4 cycles; the 12-cycle period repeats.
- Capture isolation:
  - Stimulus: change `s1` from 4'h0 to 4'hA on the second cycle of SHOW1.
  - Response: `seg` stays 7'b1000000 for the rest of that SHOW1; the next SHOW1 shows 7'b0001000.
- Mutual exclusion:
  - Stimulus: random `s1`/`s2` for 500 cycles.
  - Response: `display1`|`display2` is never 0. Between any two digit-lit windows there are exactly 2 dark cycles with `seg`=7'b1111111.
- Enable drop:
  - Stimulus: take `en` low mid-SHOW2 for 5 cycles, then return it high.
  - Response: dark from the next edge; on restart, 2 blank cycles, then SHOW1.
- Async reset mid-phase:
  - Stimulus: assert `reset`=0 between clock edges during SHOW1.
  - Response: outputs go dark immediately (before the next edge); the sequence restarts from BLANK1 after release.
- Decoder sweep:
  - Stimulus: `s1` stepped through 0–F, one value per frame.
  - Response: each SHOW1 shows the package's expected pattern for that digit.
